// File: rtl/banked_reg_bank.sv
// Register bank with banked SP/LR per mode and a serial context save/restore engine.
// Latency: reads combinational; writes visible the cycle after commit; save/restore of N-3+1 words at one per accepted beat.
// Backpressure: ctx_ready=0 holds ctx_index/ctx_data_out; enable path is stalled while ctx_busy=1.
module banked_reg_bank #(
    parameter int REGISTER_LENGTH = 32,
    parameter int NUM_REGS        = 16,
    parameter int NUM_MODES       = 4,
    parameter int DATA_AREA_START = 8192,
    localparam int IW = $clog2(NUM_REGS),
    localparam int MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [MW-1:0]              mode,
    input  logic [2:0]                 control,
    input  logic [IW-1:0]              register_source_A,
    input  logic [IW-1:0]              register_source_B,
    input  logic [IW-1:0]              register_Dest,
    input  logic [REGISTER_LENGTH-1:0] ALU_result,
    input  logic [REGISTER_LENGTH-1:0] data_from_memory,
    input  logic [REGISTER_LENGTH-1:0] new_stack_pointer,
    input  logic [REGISTER_LENGTH-1:0] new_PC,
    output logic [REGISTER_LENGTH-1:0] read_data_A,
    output logic [REGISTER_LENGTH-1:0] read_data_B,
    output logic [REGISTER_LENGTH-1:0] memory_output,
    output logic [REGISTER_LENGTH-1:0] current_PC,
    output logic [REGISTER_LENGTH-1:0] current_SP,
    input  logic                       ctx_start,
    input  logic                       ctx_dir,
    input  logic                       ctx_ready,
    input  logic [REGISTER_LENGTH-1:0] ctx_data_in,
    output logic                       ctx_valid,
    output logic [IW-1:0]              ctx_index,
    output logic [REGISTER_LENGTH-1:0] ctx_data_out,
    output logic                       ctx_busy,
    output logic                       ctx_done
);

    localparam int                       NGEN       = NUM_REGS - 3;
    localparam logic [IW-1:0]            PC_IDX     = IW'(NUM_REGS - 1);
    localparam logic [IW-1:0]            SP_IDX     = IW'(NUM_REGS - 2);
    localparam logic [IW-1:0]            LR_IDX     = IW'(NUM_REGS - 3);
    localparam logic [REGISTER_LENGTH-1:0] MAX_NUMBER = '1;
    localparam logic [REGISTER_LENGTH-1:0] R0_INIT    = REGISTER_LENGTH'(DATA_AREA_START);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t                       state_q, state_d;
    logic                         dir_q;
    logic [REGISTER_LENGTH-1:0]   gen_q [NGEN];
    logic [REGISTER_LENGTH-1:0]   sp_q  [NUM_MODES];
    logic [REGISTER_LENGTH-1:0]   lr_q  [NUM_MODES];
    logic [REGISTER_LENGTH-1:0]   pc_q;
    logic                         commit;
    logic                         xfer_fire;
    logic                         xfer_last;

    // Reads come straight from state, so a same-edge write is never forwarded.
    function automatic logic [REGISTER_LENGTH-1:0] read_reg(input logic [IW-1:0] idx);
        logic [REGISTER_LENGTH-1:0] val;
        if (idx == PC_IDX)
            val = pc_q;
        else if (idx == SP_IDX)
            val = sp_q[mode];
        else if (idx == LR_IDX)
            val = lr_q[mode];
        else
            val = gen_q[idx];
        return val;
    endfunction

    assign read_data_A   = read_reg(register_source_A);
    assign read_data_B   = read_reg(register_source_B);
    assign memory_output = read_reg(register_Dest);
    assign ctx_data_out  = read_reg(ctx_index);
    assign current_PC    = pc_q;
    assign current_SP    = sp_q[mode];

    assign ctx_valid = (state_q == XFER);
    assign ctx_busy  = (state_q != IDLE);
    assign ctx_done  = (state_q == DONE);

    assign commit    = enable && (state_q == IDLE);
    assign xfer_fire = (state_q == XFER) && ctx_ready;
    // LR is the last word and sits at the index right after the general registers.
    assign xfer_last = (ctx_index == LR_IDX);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ctx_start) state_d = XFER;
            XFER:    if (xfer_fire && xfer_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ctx_index <= '0;
            dir_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && ctx_start) begin
                ctx_index <= '0;
                dir_q     <= ctx_dir;
            end else if (xfer_fire) begin
                ctx_index <= xfer_last ? '0 : ctx_index + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q <= '0;
            for (int i = 0; i < NGEN; i++)
                gen_q[i] <= (i == 0) ? R0_INIT : '0;
            for (int m = 0; m < NUM_MODES; m++) begin
                sp_q[m] <= MAX_NUMBER;
                lr_q[m] <= '0;
            end
        end else begin
            if (commit) begin
                pc_q        <= new_PC;
                sp_q[mode]  <= (control == 3'd2) ? MAX_NUMBER : new_stack_pointer;
                case (control)
                    3'd1, 3'd3: begin
                        if (register_Dest == LR_IDX)
                            lr_q[mode] <= (control == 3'd1) ? ALU_result : data_from_memory;
                        else if (register_Dest != PC_IDX && register_Dest != SP_IDX)
                            gen_q[register_Dest] <= (control == 3'd1) ? ALU_result : data_from_memory;
                    end
                    3'd2:    gen_q[0]   <= R0_INIT;
                    3'd4:    lr_q[mode] <= pc_q;
                    default: ;
                endcase
            end
            if (xfer_fire && dir_q) begin
                if (xfer_last)
                    lr_q[mode] <= ctx_data_in;
                else
                    gen_q[ctx_index] <= ctx_data_in;
            end
        end
    end

endmodule

// File: tb/tb_banked_reg_bank.sv
// Directed bench for banked_reg_bank: register updates, banking, context save/restore, reset abort.
module tb_banked_reg_bank;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [1:0]  mode;
    logic [2:0]  control;
    logic [3:0]  register_source_A, register_source_B, register_Dest;
    logic [31:0] ALU_result, data_from_memory, new_stack_pointer, new_PC;
    logic [31:0] read_data_A, read_data_B, memory_output, current_PC, current_SP;
    logic        ctx_start, ctx_dir, ctx_ready;
    logic [31:0] ctx_data_in;
    logic        ctx_valid;
    logic [3:0]  ctx_index;
    logic [31:0] ctx_data_out;
    logic        ctx_busy, ctx_done;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    banked_reg_bank dut (
        .clock(clock), .reset(reset), .enable(enable), .mode(mode), .control(control),
        .register_source_A(register_source_A), .register_source_B(register_source_B),
        .register_Dest(register_Dest), .ALU_result(ALU_result),
        .data_from_memory(data_from_memory), .new_stack_pointer(new_stack_pointer),
        .new_PC(new_PC), .read_data_A(read_data_A), .read_data_B(read_data_B),
        .memory_output(memory_output), .current_PC(current_PC), .current_SP(current_SP),
        .ctx_start(ctx_start), .ctx_dir(ctx_dir), .ctx_ready(ctx_ready),
        .ctx_data_in(ctx_data_in), .ctx_valid(ctx_valid), .ctx_index(ctx_index),
        .ctx_data_out(ctx_data_out), .ctx_busy(ctx_busy), .ctx_done(ctx_done)
    );

    always #50 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL scoreboard_empty observed=%h expected=queued_entry", obs);
        end else begin
            e = exp_q.pop_front();
            cmp(e.tag, obs, e.val);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic rd_check(input string tag, input logic [3:0] idx, input logic [31:0] exp);
        register_source_A = idx;
        push(tag, exp);
        #1;
        pop_check(read_data_A);
    endtask

    initial begin
        int words, dones, cycles, exp_idx;

        reset = 1'b0; enable = 1'b0; mode = 2'd0; control = 3'd0;
        register_source_A = '0; register_source_B = '0; register_Dest = '0;
        ALU_result = '0; data_from_memory = '0; new_stack_pointer = '0; new_PC = '0;
        ctx_start = 1'b0; ctx_dir = 1'b0; ctx_ready = 1'b0; ctx_data_in = '0;

        // Reset state
        #10;
        cmp("rst_busy", ctx_busy, 0);
        cmp("rst_valid", ctx_valid, 0);
        cmp("rst_done", ctx_done, 0);
        cmp("rst_index", ctx_index, 0);
        tick;
        reset = 1'b1;
        tick;
        for (int m = 0; m < 4; m++) begin
            mode = m[1:0];
            #1;
            cmp($sformatf("rst_sp_mode%0d", m), current_SP, 32'hFFFF_FFFF);
            rd_check($sformatf("rst_lr_mode%0d", m), 4'd13, 32'h0);
        end
        mode = 2'd0;
        rd_check("rst_r0", 4'd0, 32'd8192);
        rd_check("rst_r7", 4'd7, 32'h0);
        cmp("rst_pc", current_PC, 32'h0);

        // control=1 into R3; read before the edge sees the old value
        control = 3'd1; register_Dest = 4'd3; ALU_result = 32'hA5;
        new_PC = 32'h4; new_stack_pointer = 32'h1000; enable = 1'b1;
        rd_check("r3_pre_commit", 4'd3, 32'h0);
        tick;
        enable = 1'b0;
        rd_check("r3_written", 4'd3, 32'hA5);
        cmp("pc_after_w1", current_PC, 32'h4);
        cmp("sp_after_w1", current_SP, 32'h1000);

        // Write to SP index is suppressed; SP takes new_stack_pointer
        register_Dest = 4'd14; ALU_result = 32'hDEAD; new_stack_pointer = 32'h2000;
        new_PC = 32'h8; enable = 1'b1;
        tick;
        enable = 1'b0;
        cmp("sp_dest_suppressed", current_SP, 32'h2000);
        push("memout_sp", 32'h2000);
        #1;
        pop_check(memory_output);
        rd_check("r3_unchanged", 4'd3, 32'hA5);

        // control=3 from memory
        control = 3'd3; register_Dest = 4'd5; data_from_memory = 32'h55; enable = 1'b1;
        tick;
        enable = 1'b0;
        rd_check("r5_from_mem", 4'd5, 32'h55);
        push("memout_r5", 32'h55);
        #1;
        pop_check(memory_output);

        // Overwrite R0, then reinit
        control = 3'd1; register_Dest = 4'd0; ALU_result = 32'h77; enable = 1'b1;
        tick;
        rd_check("r0_written", 4'd0, 32'h77);
        control = 3'd2;
        tick;
        enable = 1'b0;
        rd_check("r0_reinit", 4'd0, 32'd8192);
        cmp("sp_reinit", current_SP, 32'hFFFF_FFFF);

        // Write to PC index is suppressed; PC takes new_PC
        control = 3'd1; register_Dest = 4'd15; ALU_result = 32'h999; new_PC = 32'hC; enable = 1'b1;
        tick;
        enable = 1'b0;
        cmp("pc_dest_suppressed", current_PC, 32'hC);

        // Banked LR: mode 1 captures the pre-update PC
        mode = 2'd1; control = 3'd0; new_PC = 32'h40; new_stack_pointer = 32'h3000; enable = 1'b1;
        tick;
        control = 3'd4; new_PC = 32'h44;
        tick;
        enable = 1'b0;
        rd_check("lr1_from_pc", 4'd13, 32'h40);
        cmp("pc_after_lr", current_PC, 32'h44);
        mode = 2'd0;
        rd_check("lr0_untouched", 4'd13, 32'h0);

        // control=7 writes no register
        control = 3'd7; register_Dest = 4'd3; ALU_result = 32'h1; new_PC = 32'h48;
        new_stack_pointer = 32'h1234; enable = 1'b1;
        tick;
        enable = 1'b0;
        rd_check("ctl7_no_write", 4'd3, 32'hA5);

        // control=1 to LR index under mode 2
        mode = 2'd2; control = 3'd1; register_Dest = 4'd13; ALU_result = 32'h222;
        new_PC = 32'h4C; enable = 1'b1;
        tick;
        enable = 1'b0; control = 3'd0;
        rd_check("lr2_written", 4'd13, 32'h222);
        mode = 2'd1;
        rd_check("lr1_kept", 4'd13, 32'h40);

        // Save under mode 1, started together with an enable commit
        for (int i = 0; i < 14; i++) begin
            logic [31:0] v;
            v = 32'h0;
            if (i == 0)  v = 32'd8192;
            if (i == 3)  v = 32'hA5;
            if (i == 5)  v = 32'h55;
            if (i == 13) v = 32'h40;
            push($sformatf("save_word%0d", i), v);
        end
        ctx_dir = 1'b0; ctx_start = 1'b1; enable = 1'b1; control = 3'd0;
        new_PC = 32'h80; new_stack_pointer = 32'h3000;
        tick;
        ctx_start = 1'b0; new_PC = 32'hBAD; new_stack_pointer = 32'hBAD;
        cmp("start_busy", ctx_busy, 1);
        cmp("start_pc_committed", current_PC, 32'h80);
        words = 0; dones = 0; exp_idx = 0;
        for (int c = 0; c < 100 && ctx_busy; c++) begin
            ctx_ready = (c % 2 == 0);
            #1;
            if (ctx_valid && ctx_ready) begin
                cmp("save_index", ctx_index, exp_idx);
                pop_check(ctx_data_out);
                exp_idx++;
                words++;
            end
            if (ctx_done) dones++;
            tick;
        end
        cmp("save_finished", ctx_busy, 0);
        cmp("save_words", words, 14);
        cmp("save_done_once", dones, 1);
        cmp("save_queue_drained", exp_q.size(), 0);
        cmp("save_pc_frozen", current_PC, 32'h80);
        cmp("save_sp_frozen", current_SP, 32'h3000);
        enable = 1'b0;

        // Restore under mode 1, ready held high
        ctx_dir = 1'b1; ctx_ready = 1'b1; ctx_start = 1'b1; ctx_data_in = 32'h100;
        tick;
        ctx_start = 1'b0;
        cycles = 1;
        while (!ctx_done && cycles < 40) begin
            ctx_data_in = 32'h100 + {28'h0, ctx_index};
            tick;
            cycles++;
        end
        cmp("restore_latency", cycles, 15);
        cmp("restore_done_busy", ctx_busy, 1);
        cmp("restore_done_valid", ctx_valid, 0);
        tick;
        cmp("restore_idle_busy", ctx_busy, 0);
        cmp("restore_idle_done", ctx_done, 0);
        rd_check("restore_r5", 4'd5, 32'h105);
        rd_check("restore_r0", 4'd0, 32'h100);
        rd_check("restore_r12", 4'd12, 32'h10C);
        rd_check("restore_lr1", 4'd13, 32'h10D);
        mode = 2'd2;
        rd_check("restore_lr2_kept", 4'd13, 32'h222);

        // Reset in the middle of a save
        mode = 2'd0; ctx_dir = 1'b0; ctx_ready = 1'b1; ctx_start = 1'b1;
        tick;
        ctx_start = 1'b0;
        for (int c = 0; c < 40 && ctx_index != 4'd6; c++) tick;
        cmp("abort_reached_idx6", ctx_index, 6);
        reset = 1'b0;
        #1;
        cmp("abort_busy", ctx_busy, 0);
        cmp("abort_valid", ctx_valid, 0);
        cmp("abort_index", ctx_index, 0);
        cmp("abort_pc", current_PC, 32'h0);
        cmp("abort_sp", current_SP, 32'hFFFF_FFFF);
        rd_check("abort_r0", 4'd0, 32'd8192);
        rd_check("abort_r5", 4'd5, 32'h0);
        mode = 2'd1;
        rd_check("abort_lr1", 4'd13, 32'h0);
        tick;
        tick;
        reset = 1'b1;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            if (ctx_done) dones++;
            tick;
        end
        cmp("abort_no_done", dones, 0);
        cmp("abort_stays_idle", ctx_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/banked_reg_bank.md
BANKED_REG_BANK -- requirements
Module: banked_reg_bank

Interface
REQ-001 Parameter REGISTER_LENGTH, default 32: width of every register and data port.
REQ-002 Parameter NUM_REGS, default 16: architectural registers; index NUM_REGS-1 = PC, NUM_REGS-2 = SP, NUM_REGS-3 = LR.
REQ-003 Parameter NUM_MODES, default 4: processor modes, each with its own banked SP and LR.
REQ-004 Parameter DATA_AREA_START, default 8192: reset value of R0.
REQ-005 Derived: IW = clog2(NUM_REGS), MW = clog2(NUM_MODES), MAX_NUMBER = 2**REGISTER_LENGTH-1.
REQ-006 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-007 Ports, clock and reset first:
 clock  in  1  rising-edge clock
 reset  in  1  asynchronous active-low reset
 enable  in  1  commit strobe for the register-update path
 mode  in  MW  current mode; selects the banked SP/LR
 control  in  3  0 none, 1 RD=ALU_result, 2 reinit, 3 RD=data_from_memory, 4 LR(mode)=PC
 register_source_A, register_source_B, register_Dest  in  IW  register indices
 ALU_result, data_from_memory, new_stack_pointer, new_PC  in  REGISTER_LENGTH  write data
 read_data_A, read_data_B, memory_output  out  REGISTER_LENGTH  read ports (A, B, RD)
 current_PC, current_SP  out  REGISTER_LENGTH  PC; SP of current mode
 ctx_start  in  1  start a context transfer (one-cycle pulse)
 ctx_dir  in  1  0 save (registers to memory), 1 restore (memory to registers)
 ctx_ready  in  1  memory side accepts or supplies the current word
 ctx_data_in  in  REGISTER_LENGTH  restore data
 ctx_valid  out  1  transfer word pending
 ctx_index  out  IW  register index of the pending word
 ctx_data_out  out  REGISTER_LENGTH  save data (register ctx_index)
 ctx_busy, ctx_done  out  1  transfer active; one-cycle completion pulse

Function
REQ-008 Storage: NUM_REGS-3 general registers, one PC, NUM_MODES SPs, NUM_MODES LRs.
REQ-009 Reads are combinational; index NUM_REGS-2 returns SP[mode], NUM_REGS-3 returns LR[mode], NUM_REGS-1 returns PC.
REQ-010 Read bypass: when a write to the addressed general register or LR commits this edge, the read ports SHALL return the old value (no forwarding); new value visible the cycle after.
REQ-011 On enable=1 and FSM IDLE: PC<=new_PC; SP[mode]<=MAX_NUMBER if control=2, else new_stack_pointer.
REQ-012 control=1/3: register_Dest<=ALU_result/data_from_memory, suppressed when register_Dest is PC or SP; a write to LR index writes LR[mode].
REQ-013 control=2: R0<=DATA_AREA_START; control=4: LR[mode]<=current PC (pre-update value); control 5-7: no register write.
REQ-014 FSM states IDLE, XFER, DONE; reset state IDLE.
REQ-015 IDLE->XFER on ctx_start=1: ctx_index<=0, ctx_busy<=1, ctx_valid<=1; ctx_start ignored outside IDLE.
REQ-016 XFER: word transferred on each edge with ctx_valid=1 and ctx_ready=1; ctx_data_out = register ctx_index (save); register ctx_index<=ctx_data_in (restore).
REQ-017 XFER covers general registers 0..NUM_REGS-4 then LR[mode], in that order; after the LR word, ->DONE.
REQ-018 ctx_ready=0 holds ctx_index and data stable; no timeout.
REQ-019 DONE: ctx_done=1, ctx_valid=0 for one cycle, then ->IDLE with ctx_busy=0.
REQ-020 While ctx_busy=1 the enable path SHALL be stalled entirely (PC, SP, registers unchanged); reads remain valid.
REQ-021 Simultaneous ctx_start and enable in IDLE: the enable update commits, the transfer starts the same edge.

Reset
REQ-022 reset=0 asynchronously: R0=DATA_AREA_START, other general registers 0, PC=0, all SPs=MAX_NUMBER, all LRs=0.
REQ-023 reset=0 asynchronously: FSM IDLE, ctx_index=0, ctx_valid=0, ctx_busy=0, ctx_done=0; a transfer in progress is abandoned.

Verification
REQ-024 Release reset -> read R0=8192, current_PC=0, current_SP=0xFFFFFFFF for every mode.
REQ-025 enable=1, control=1, register_Dest=3, ALU_result=0xA5 -> R3=0xA5 next cycle; register_Dest=14 leaves SP=new_stack_pointer only.
REQ-026 mode=1, control=4, PC=0x40 -> LR[1]=0x40, LR[0] stays 0; read index 13 under mode 0 returns 0.
REQ-027 Save with ctx_ready toggling 1/0 -> 14 words in order R0..R12, LR[mode]; ctx_done exactly once; PC frozen despite enable=1.
REQ-028 Restore with ctx_data_in=0x100+index, ctx_ready=1 -> done 15 cycles after start; R5=0x105, LR[mode]=0x10D.
REQ-029 reset=0 at index 6 of a save -> ctx_busy=0 immediately, registers at reset values, no ctx_done.
